uart_tx_fifo: RTL and testbench

Byte FIFO and launch controller sitting directly upstream of the UART transmitter. It accepts bytes from the CPU-side write port, buffers up to 2^DEPTH_LOG2 of them, and feeds them one at a time to the transmitter through its `start`/`data`/`bsy` handshake. It runs entirely in the `bitclk` domain, so every cycle count below is in bit periods.

---
 rtl/uart_tx_fifo.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// ------------
// Byte FIFO and launch controller placed directly in front of the UART
// transmitter. Bytes written from the CPU side are buffered in a circular
// buffer and handed to the transmitter one at a time through its
// start/data/bsy handshake. Everything runs in the bitclk domain.
//
// Ports:
//   bitclk    in   bit-rate clock, all state updates on its rising edge
//   reset_n   in   asynchronous active-low reset
//   wr_en     in   write strobe, one byte offered per cycle while high
//   wr_data   in   [7:0] byte to enqueue
//   flush     in   synchronous FIFO clear (pointers and count only)
//   clr_ovf   in   synchronous clear of the sticky overflow flag
//   tx_bsy    in   transmitter busy flag
//   tx_start  out  registered one-cycle launch pulse to the transmitter
//   tx_data   out  [7:0] registered byte presented to the transmitter
//   full      out  count == DEPTH
//   empty     out  count == 0
//   count     out  [DEPTH_LOG2:0] number of stored bytes
//   overflow  out  sticky flag, set when a write to a full FIFO was dropped

module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  bitclk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  flush,
    input  logic                  clr_ovf,
    input  logic                  tx_bsy,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [7:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wptr;
    logic [DEPTH_LOG2-1:0]  rptr;
    logic                   pop;
    logic                   start_next;
    logic                   wr_accept;
    logic                   wr_drop;

    // Flags come straight from the count register, so they reflect the
    // previous edge and a same-cycle pop can never make room for a write.
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    // Flush discards a concurrent write outright; it is neither stored nor
    // counted as an overflow.
    assign wr_accept = wr_en && !full && !flush;
    assign wr_drop   = wr_en &&  full && !flush;

    // Launch controller. A pop is always paired with a fresh tx_start pulse.
    // A flush in the same cycle cancels the pop and holds the current state,
    // so the controller re-evaluates against the emptied FIFO next cycle.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        start_next = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !tx_bsy && !flush) begin
                    pop        = 1'b1;
                    start_next = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                // No busy seen: the transmitter missed the pulse, so re-issue
                // it with the same tx_data and without touching the FIFO.
                if (tx_bsy) begin
                    state_next = WAIT_DONE;
                end else begin
                    start_next = 1'b1;
                    state_next = LAUNCH;
                end
            end
            WAIT_DONE: begin
                if (!tx_bsy) begin
                    if (empty) begin
                        state_next = IDLE;
                    end else if (!flush) begin
                        pop        = 1'b1;
                        start_next = 1'b1;
                        state_next = LAUNCH;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Controller registers; tx_data only moves on a pop so it stays stable
    // across retries and for the whole frame.
    always_ff @(posedge bitclk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state    <= state_next;
            tx_start <= start_next;
            if (pop) begin
                tx_data <= mem[rptr];
            end
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge bitclk or negedge reset_n) begin
        if (!reset_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (wr_accept) begin
                    wptr <= wptr + 1'b1;
                end
                if (pop) begin
                    rptr <= rptr + 1'b1;
                end
                count <= count + (DEPTH_LOG2 + 1)'(wr_accept)
                               - (DEPTH_LOG2 + 1)'(pop);
            end
            // A dropped write in the same cycle as clr_ovf keeps the flag set.
            if (wr_drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage array; contents are don't-care after reset since the pointers
    // and count define what is valid.
    always_ff @(posedge bitclk) begin
        if (wr_accept) begin
            mem[wptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// ---------------
// Directed bench for uart_tx_fifo (DEPTH_LOG2 = 2). A small transmitter model
// answers each launch pulse with a 13-cycle busy frame when enabled; otherwise
// tx_bsy is driven by hand. Inputs change and outputs are sampled on the
// falling edge of bitclk.

module tb_uart_tx_fifo;

    localparam int DL2 = 2;

    logic           bitclk;
    logic           reset_n;
    logic           wr_en;
    logic [7:0]     wr_data;
    logic           flush;
    logic           clr_ovf;
    logic           tx_bsy;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           full;
    logic           empty;
    logic [DL2:0]   count;
    logic           overflow;

    logic           auto_tx;
    logic           model_bsy;
    logic           man_bsy;
    logic [7:0]     launch_log [$];

    int n_cmp;
    int n_fail;

    uart_tx_fifo #(.DEPTH_LOG2(DL2)) dut (
        .bitclk   (bitclk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .clr_ovf  (clr_ovf),
        .tx_bsy   (tx_bsy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    assign tx_bsy = auto_tx ? model_bsy : man_bsy;

    initial begin
        bitclk = 1'b0;
        forever #5 bitclk = ~bitclk;
    end

    // Transmitter model: a pulse seen before edge E latches at E, busy is
    // high for the 13 edges after that and low again at the 14th.
    initial begin
        model_bsy = 1'b0;
        forever begin
            @(negedge bitclk);
            if (auto_tx && tx_start === 1'b1) begin
                @(posedge bitclk);
                #1 model_bsy = 1'b1;
                repeat (13) @(posedge bitclk);
                #1 model_bsy = 1'b0;
            end
        end
    end

    // Record every byte presented with tx_start high.
    initial begin
        forever begin
            @(negedge bitclk);
            if (tx_start === 1'b1) launch_log.push_back(tx_data);
        end
    end

    task automatic tick();
        @(posedge bitclk);
        @(negedge bitclk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
        clr_ovf = 1'b0; man_bsy = 1'b0; auto_tx = 1'b0;
        tick(); tick();
        n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tx_start got %b want 0", tx_start); end
        n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_tx_data got %h want 00", tx_data); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full got %b want 0", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overflow got %b want 0", overflow); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int seen;
        launch_log.delete();
        auto_tx = 1'b1;
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("[TB] FAIL single_count_e0 got %0d want 1", count); end
        n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("[TB] FAIL single_start_e0 got %b want 0", tx_start); end
        tick();
        n_cmp++; if (tx_start !== 1'b1) begin n_fail++; $display("[TB] FAIL single_start_e1 got %b want 1", tx_start); end
        n_cmp++; if (tx_data !== 8'hA5) begin n_fail++; $display("[TB] FAIL single_data_e1 got %h want a5", tx_data); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL single_empty_e1 got %b want 1", empty); end
        tick();
        n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("[TB] FAIL single_start_e2 got %b want 0", tx_start); end
        seen = 0;
        repeat (20) begin
            tick();
            if (tx_start === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL single_extra_start got %0d pulses want 0", seen); end
        n_cmp++; if (launch_log.size() !== 1) begin n_fail++; $display("[TB] FAIL single_launches got %0d want 1", launch_log.size()); end
    endtask

    task automatic test_burst();
        logic [7:0] exp_log [4];
        exp_log[0] = 8'h10; exp_log[1] = 8'h01; exp_log[2] = 8'h02; exp_log[3] = 8'h03;
        launch_log.delete();
        // Lead byte so the burst lands while its frame is finishing.
        wr_en = 1'b1; wr_data = 8'h10;
        tick();
        wr_en = 1'b0;
        tick();
        n_cmp++; if (tx_start !== 1'b1) begin n_fail++; $display("[TB] FAIL burst_lead_start got %b want 1", tx_start); end
        repeat (12) tick();
        wr_en = 1'b1; wr_data = 8'h01;
        tick();
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("[TB] FAIL burst_count_1 got %0d want 1", count); end
        wr_data = 8'h02;
        tick();
        n_cmp++; if (count !== 3'd2) begin n_fail++; $display("[TB] FAIL burst_count_2 got %0d want 2", count); end
        wr_data = 8'h03;
        tick();
        wr_en = 1'b0;
        n_cmp++; if (count !== 3'd2) begin n_fail++; $display("[TB] FAIL burst_count_3 got %0d want 2", count); end
        n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'h01) begin n_fail++; $display("[TB] FAIL burst_launch_01 got start=%b data=%h want 1/01", tx_start, tx_data); end
        repeat (14) tick();
        n_cmp++; if (tx_start !== 1'b0 || tx_data !== 8'h01) begin n_fail++; $display("[TB] FAIL burst_hold_01 got start=%b data=%h want 0/01", tx_start, tx_data); end
        tick();
        n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'h02 || count !== 3'd1) begin n_fail++; $display("[TB] FAIL burst_launch_02 got start=%b data=%h count=%0d want 1/02/1", tx_start, tx_data, count); end
        repeat (15) tick();
        n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'h03 || count !== 3'd0) begin n_fail++; $display("[TB] FAIL burst_launch_03 got start=%b data=%h count=%0d want 1/03/0", tx_start, tx_data, count); end
        repeat (20) tick();
        n_cmp++;
        if (launch_log.size() !== 4) begin
            n_fail++; $display("[TB] FAIL burst_log_size got %0d want 4", launch_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (launch_log[i] !== exp_log[i]) begin
                    n_fail++; $display("[TB] FAIL burst_order[%0d] got %h want %h", i, launch_log[i], exp_log[i]);
                end
            end
        end
    endtask

    task automatic test_full();
        int t;
        logic [7:0] exp_b;
        logic [DL2:0] exp_c;
        auto_tx = 1'b0; man_bsy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'hA0 + 8'(i);
            tick();
            if (i == 2) begin
                n_cmp++; if (full !== 1'b0) begin n_fail++; $display("[TB] FAIL full_after3 got %b want 0", full); end
            end
            if (i == 3) begin
                n_cmp++; if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL full_after4 got full=%b count=%0d ovf=%b want 1/4/0", full, count, overflow); end
            end
        end
        wr_en = 1'b0;
        n_cmp++; if (overflow !== 1'b1 || count !== 3'd4 || full !== 1'b1) begin n_fail++; $display("[TB] FAIL full_drop got ovf=%b count=%0d full=%b want 1/4/1", overflow, count, full); end
        clr_ovf = 1'b1;
        tick();
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_ovf got %b want 0", overflow); end
        wr_en = 1'b1; wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        n_cmp++; if (overflow !== 1'b1 || count !== 3'd4) begin n_fail++; $display("[TB] FAIL ovf_set_wins got ovf=%b count=%0d want 1/4", overflow, count); end
        tick();
        clr_ovf = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_ovf2 got %b want 0", overflow); end
        // Drain while refilling: both pointers wrap past DEPTH-1.
        launch_log.delete();
        man_bsy = 1'b0; auto_tx = 1'b1;
        for (int i = 0; i < 10; i++) begin
            t = 0;
            while (tx_start !== 1'b1 && t < 40) begin tick(); t++; end
            exp_b = (i < 4) ? 8'hA0 + 8'(i) : 8'hB0 + 8'(i - 4);
            exp_c = (i <= 6) ? 3'd3 : 3'(9 - i);
            n_cmp++;
            if (tx_start !== 1'b1) begin
                n_fail++; $display("[TB] FAIL wrap_timeout[%0d] got no launch within 40 cycles", i);
                break;
            end
            if (tx_data !== exp_b || count !== exp_c) begin
                n_fail++; $display("[TB] FAIL wrap_launch[%0d] got data=%h count=%0d want %h/%0d", i, tx_data, count, exp_b, exp_c);
            end
            if (i < 6) begin
                wr_en = 1'b1; wr_data = 8'hB0 + 8'(i);
                tick();
                wr_en = 1'b0;
            end else begin
                tick();
            end
        end
        repeat (20) tick();
        n_cmp++; if (launch_log.size() !== 10 || empty !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_total got launches=%0d empty=%b want 10/1", launch_log.size(), empty); end
    endtask

    task automatic test_missed_ack();
        logic exp_s;
        auto_tx = 1'b0; man_bsy = 1'b0;
        wr_en = 1'b1; wr_data = 8'h5A;
        tick();
        wr_data = 8'h6B;
        tick();
        wr_en = 1'b0;
        n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'h5A || count !== 3'd1) begin n_fail++; $display("[TB] FAIL miss_first got start=%b data=%h count=%0d want 1/5a/1", tx_start, tx_data, count); end
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_s = (k % 2 == 1);
            n_cmp++; if (tx_start !== exp_s || tx_data !== 8'h5A || count !== 3'd1) begin n_fail++; $display("[TB] FAIL miss_retry[%0d] got start=%b data=%h count=%0d want %b/5a/1", k, tx_start, tx_data, count, exp_s); end
        end
        man_bsy = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (tx_start !== 1'b0 || tx_data !== 8'h5A) begin n_fail++; $display("[TB] FAIL miss_acked got start=%b data=%h want 0/5a", tx_start, tx_data); end
        man_bsy = 1'b0;
        tick();
        n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'h6B || count !== 3'd0) begin n_fail++; $display("[TB] FAIL miss_next got start=%b data=%h count=%0d want 1/6b/0", tx_start, tx_data, count); end
        man_bsy = 1'b1;
        tick(); tick();
        man_bsy = 1'b0;
        tick(); tick();
        n_cmp++; if (tx_start !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("[TB] FAIL miss_end got start=%b empty=%b want 0/1", tx_start, empty); end
    endtask

    task automatic test_flush();
        int seen;
        launch_log.delete();
        auto_tx = 1'b1;
        wr_en = 1'b1; wr_data = 8'hC0;
        tick();
        wr_data = 8'hC1;
        tick();
        wr_data = 8'hC2;
        tick();
        wr_data = 8'hC3;
        tick();
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("[TB] FAIL flush_pre_count got %0d want 3", count); end
        flush = 1'b1; wr_data = 8'hFF;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        n_cmp++; if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || tx_data !== 8'hC0) begin n_fail++; $display("[TB] FAIL flush_result got count=%0d empty=%b ovf=%b data=%h want 0/1/0/c0", count, empty, overflow, tx_data); end
        seen = 0;
        repeat (20) begin
            tick();
            if (tx_start === 1'b1 || tx_data !== 8'hC0) seen++;
        end
        n_cmp++; if (seen !== 0 || launch_log.size() !== 1 || tx_bsy !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_inflight got disturbances=%0d launches=%0d bsy=%b want 0/1/0", seen, launch_log.size(), tx_bsy); end
    endtask

    task automatic test_reset_mid();
        int seen;
        auto_tx = 1'b1;
        wr_en = 1'b1; wr_data = 8'hD0;
        tick();
        wr_data = 8'hD1;
        tick();
        wr_data = 8'hD2;
        tick();
        wr_data = 8'hD3;
        tick();
        wr_en = 1'b0;
        n_cmp++; if (count !== 3'd3 || tx_data !== 8'hD0) begin n_fail++; $display("[TB] FAIL rmid_pre got count=%0d data=%h want 3/d0", count, tx_data); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (tx_start !== 1'b0 || tx_data !== 8'h00 || count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_async got start=%b data=%h count=%0d empty=%b full=%b ovf=%b want 0/00/0/1/0/0", tx_start, tx_data, count, empty, full, overflow); end
        auto_tx = 1'b0; man_bsy = 1'b0;
        @(negedge bitclk);
        reset_n = 1'b1;
        seen = 0;
        repeat (20) begin
            tick();
            if (tx_start !== 1'b0 || empty !== 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL rmid_quiet got %0d bad cycles want 0", seen); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        $display("[TB] starting uart_tx_fifo bench");
        test_reset();
        test_single();
        test_burst();
        test_full();
        test_missed_ack();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
